// File: rtl/acq_sequencer.sv
// FMCW acquisition sequencer: ADF config, FIR capture, FFT/raw processing and FT245 upload,
// with per-frame ramp grouping. Define ACQ_SEQ_STATS_EN to enable the skipped-ramp counter.
module acq_sequencer #(
   parameter int RAMPS_W = 8,
   parameter int RD_DLY  = 1,
   parameter int SKIP_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               adf_done,
   input  logic               ramp_start,
   input  logic               window_valid,
   input  logic               fifo_full,
   input  logic               fifo_empty,
   input  logic               fft_done,
   input  logic               ft245_empty,
   input  logic               mode,
   input  logic [RAMPS_W-1:0] nramps,
   output logic               adf_en,
   output logic               fir_en,
   output logic               fifo_wren,
   output logic               fifo_rden,
   output logic               fft_en,
   output logic               raw_en,
   output logic               frame_start,
   output logic               frame_done,
   output logic               busy,
   output logic [2:0]         state_o,
   output logic [SKIP_W-1:0]  skip_cnt
);

   typedef enum logic [2:0] {
      CONFIG = 3'd0,
      ARM    = 3'd1,
      FIR    = 3'd2,
      PROC   = 3'd3,
      XFER   = 3'd4
   } state_t;

   localparam logic [RAMPS_W-1:0] RAMP_ONE  = {{(RAMPS_W-1){1'b0}}, 1'b1};
   localparam logic [RAMPS_W-1:0] RAMP_ZERO = {RAMPS_W{1'b0}};
   localparam logic [3:0]         RD_DLY_C  = 4'(RD_DLY);

   state_t             state_r, state_nxt_s;
   logic [RAMPS_W-1:0] ramp_idx_r, nramps_r;
   logic               mode_r;
   logic [3:0]         dly_cnt_r;
   logic               frame_start_r, frame_done_r;
   logic               leave_xfer_s, last_ramp_s, fft_gate_s, new_frame_s;

   // Frame bookkeeping decode shared by the state register and the pulse generators
   always_comb begin
      leave_xfer_s = (state_r == XFER) && ft245_empty;
      last_ramp_s  = (ramp_idx_r == (nramps_r - RAMP_ONE));
      fft_gate_s   = (dly_cnt_r >= RD_DLY_C);
      new_frame_s  = 1'b0;
      if ((state_r == ARM) && adf_done && ramp_start) begin
         new_frame_s = (ramp_idx_r == RAMP_ZERO);
      end else if (leave_xfer_s && ramp_start) begin
         // XFER->FIR counts as an ARM->FIR; the index is about to wrap when last_ramp_s
         new_frame_s = last_ramp_s;
      end else begin
         new_frame_s = 1'b0;
      end
   end

   // Next-state and datapath enable decode
   always_comb begin
      state_nxt_s = state_r;
      fir_en      = 1'b0;
      fifo_wren   = 1'b0;
      fifo_rden   = 1'b0;
      fft_en      = 1'b0;
      raw_en      = 1'b0;
      case (state_r)
         CONFIG: state_nxt_s = adf_done ? ARM : CONFIG;
         ARM: begin
            if (!adf_done) begin
               state_nxt_s = CONFIG;
            end else if (ramp_start) begin
               state_nxt_s = FIR;
            end else begin
               state_nxt_s = ARM;
            end
         end
         FIR: begin
            fir_en      = 1'b1;
            fifo_wren   = window_valid;
            state_nxt_s = fifo_full ? PROC : FIR;
         end
         PROC: begin
            if (mode_r) begin
               fifo_rden   = !fifo_empty;
               raw_en      = !fifo_empty;
               state_nxt_s = fifo_empty ? XFER : PROC;
            end else begin
               fifo_rden   = 1'b1;
               fft_en      = fft_gate_s;
               state_nxt_s = (fft_done && fft_gate_s) ? XFER : PROC;
            end
         end
         XFER: begin
            if (ft245_empty) begin
               state_nxt_s = ramp_start ? FIR : ARM;
            end else begin
               state_nxt_s = XFER;
            end
         end
         default: state_nxt_s = CONFIG;
      endcase
   end

   // State, ramp/frame counters, latched frame settings and registered frame pulses
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r       <= CONFIG;
         ramp_idx_r    <= RAMP_ZERO;
         nramps_r      <= RAMP_ONE;
         mode_r        <= 1'b0;
         dly_cnt_r     <= 4'd0;
         frame_start_r <= 1'b0;
         frame_done_r  <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         frame_start_r <= new_frame_s;
         frame_done_r  <= leave_xfer_s && last_ramp_s;
         if (state_r == PROC) begin
            dly_cnt_r <= (dly_cnt_r == RD_DLY_C) ? dly_cnt_r : dly_cnt_r + 4'd1;
         end else begin
            dly_cnt_r <= 4'd0;
         end
         if (leave_xfer_s) begin
            ramp_idx_r <= last_ramp_s ? RAMP_ZERO : ramp_idx_r + RAMP_ONE;
         end
         if (new_frame_s) begin
            mode_r   <= mode;
            nramps_r <= (nramps == RAMP_ZERO) ? RAMP_ONE : nramps;
         end
      end
   end

`ifdef ACQ_SEQ_STATS_EN
   logic [SKIP_W-1:0] skip_cnt_r;
   logic              skip_s;

   assign skip_s = (state_r == XFER) && ramp_start && !ft245_empty;

   // Saturating count of ramps lost while the FT245 was still draining
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         skip_cnt_r <= {SKIP_W{1'b0}};
      end else if (skip_s && (skip_cnt_r != {SKIP_W{1'b1}})) begin
         skip_cnt_r <= skip_cnt_r + {{(SKIP_W-1){1'b0}}, 1'b1};
      end
   end

   assign skip_cnt = skip_cnt_r;
`else
   assign skip_cnt = {SKIP_W{1'b0}};
`endif

   assign adf_en      = 1'b1;
   assign frame_start = frame_start_r;
   assign frame_done  = frame_done_r;
   assign busy        = (state_r != CONFIG) && (state_r != ARM);
   assign state_o     = state_r;

endmodule

// File: tb/tb_acq_sequencer.sv
// Scoreboard bench for acq_sequencer (RD_DLY=3, SKIP_W=2); expected skip count depends on ACQ_SEQ_STATS_EN.
module tb_acq_sequencer;

   logic       clk = 1'b0;
   logic       rst_n, adf_done, ramp_start, window_valid, fifo_full, fifo_empty;
   logic       fft_done, ft245_empty, mode;
   logic [7:0] nramps;
   logic       adf_en, fir_en, fifo_wren, fifo_rden, fft_en, raw_en;
   logic       frame_start, frame_done, busy;
   logic [2:0] state_o;
   logic [1:0] skip_cnt;

   localparam logic [2:0] S_CFG = 3'd0, S_ARM = 3'd1, S_FIR = 3'd2, S_PROC = 3'd3, S_XFER = 3'd4;

   typedef struct {
      int          cyc;
      string       name;
      logic [13:0] exp;
   } item_t;

   item_t sb[$];
   int    cyc_cnt = 0;
   int    n_cmp   = 0;
   int    n_bad   = 0;

   acq_sequencer #(.RAMPS_W(8), .RD_DLY(3), .SKIP_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .adf_done(adf_done), .ramp_start(ramp_start),
      .window_valid(window_valid), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .fft_done(fft_done), .ft245_empty(ft245_empty), .mode(mode), .nramps(nramps),
      .adf_en(adf_en), .fir_en(fir_en), .fifo_wren(fifo_wren), .fifo_rden(fifo_rden),
      .fft_en(fft_en), .raw_en(raw_en), .frame_start(frame_start), .frame_done(frame_done),
      .busy(busy), .state_o(state_o), .skip_cnt(skip_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // expected vector: {adf,fir,wren,rden,fft,raw,fs,fd,busy,state[2:0],skip[1:0]}
   function automatic logic [13:0] ev(input logic [2:0] st, input logic fir, input logic wren,
                                      input logic rden, input logic fft, input logic raw,
                                      input logic fs, input logic fd, input logic [1:0] sk);
      logic bz;
      bz = (st != S_CFG) && (st != S_ARM);
      return {1'b1, fir, wren, rden, fft, raw, fs, fd, bz, st, sk};
   endfunction

   task automatic chk(input string name, input logic [13:0] exp);
      item_t it;
      it.cyc  = cyc_cnt;
      it.name = name;
      it.exp  = exp;
      sb.push_back(it);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops every expectation due in the current cycle and compares against the DUT
   always @(negedge clk) begin
      logic [13:0] got;
      item_t       it;
      got = {adf_en, fir_en, fifo_wren, fifo_rden, fft_en, raw_en,
             frame_start, frame_done, busy, state_o, skip_cnt};
      while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
         it = sb.pop_front();
         n_cmp = n_cmp + 1;
         if (it.cyc != cyc_cnt || got !== it.exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s cyc=%0d got=%b exp=%b", it.name, cyc_cnt, got, it.exp);
         end
      end
   end

   // One full FFT-mode ramp starting from ARM and ending back in ARM
   task automatic ramp(input string tag, input logic exp_fs, input logic exp_fd);
      ramp_start = 1'b1;
      tick();
      ramp_start = 1'b0;
      fifo_full  = 1'b1;
      chk({tag, "_fir"}, ev(S_FIR, 1, 0, 0, 0, 0, exp_fs, 0, 2'd0));
      tick();
      fifo_full = 1'b0;
      chk({tag, "_proc0"}, ev(S_PROC, 0, 0, 1, 0, 0, 0, 0, 2'd0));
      tick();
      tick();
      tick();
      fft_done = 1'b1;
      chk({tag, "_fft"}, ev(S_PROC, 0, 0, 1, 1, 0, 0, 0, 2'd0));
      tick();
      fft_done    = 1'b0;
      ft245_empty = 1'b1;
      chk({tag, "_xfer"}, ev(S_XFER, 0, 0, 0, 0, 0, 0, 0, 2'd0));
      tick();
      ft245_empty = 1'b0;
      chk({tag, "_arm"}, ev(S_ARM, 0, 0, 0, 0, 0, 0, exp_fd, 2'd0));
   endtask

   logic [1:0] sk_exp;

   initial begin
      rst_n = 1'b0; adf_done = 1'b0; ramp_start = 1'b0; window_valid = 1'b0;
      fifo_full = 1'b0; fifo_empty = 1'b1; fft_done = 1'b0; ft245_empty = 1'b0;
      mode = 1'b0; nramps = 8'd1;
      // reset and configuration
      tick(); tick(); tick();
      chk("reset", ev(S_CFG, 0, 0, 0, 0, 0, 0, 0, 2'd0));
      rst_n = 1'b1; adf_done = 1'b1;
      chk("cfg_wait", ev(S_CFG, 0, 0, 0, 0, 0, 0, 0, 2'd0));
      tick();
      ramp_start = 1'b1;
      chk("arm", ev(S_ARM, 0, 0, 0, 0, 0, 0, 0, 2'd0));
      // single-ramp FFT frame with 16 captured samples
      tick();
      ramp_start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         window_valid = 1'b1;
         fifo_full    = (i == 15);
         chk("fir_cap", ev(S_FIR, 1, 1, 0, 0, 0, (i == 0), 0, 2'd0));
         tick();
      end
      window_valid = 1'b0; fifo_full = 1'b0;
      chk("proc_rden", ev(S_PROC, 0, 0, 1, 0, 0, 0, 0, 2'd0));
      tick();
      fft_done = 1'b1;
      chk("early_fft_done", ev(S_PROC, 0, 0, 1, 0, 0, 0, 0, 2'd0));
      tick();
      fft_done = 1'b0;
      chk("dly2", ev(S_PROC, 0, 0, 1, 0, 0, 0, 0, 2'd0));
      tick();
      fft_done = 1'b1;
      chk("fft_en_at3", ev(S_PROC, 0, 0, 1, 1, 0, 0, 0, 2'd0));
      tick();
      fft_done = 1'b0;
      chk("xfer_hold", ev(S_XFER, 0, 0, 0, 0, 0, 0, 0, 2'd0));
      tick();
      ft245_empty = 1'b1;
      chk("xfer_drain", ev(S_XFER, 0, 0, 0, 0, 0, 0, 0, 2'd0));
      tick();
      ft245_empty = 1'b0;
      chk("frame_done1", ev(S_ARM, 0, 0, 0, 0, 0, 0, 1, 2'd0));
      // four-ramp frame; nramps change mid-frame only applies to the next frame
      nramps = 8'd4;
      ramp("f4r0", 1'b1, 1'b0);
      nramps = 8'd2;
      ramp("f4r1", 1'b0, 1'b0);
      ramp("f4r2", 1'b0, 1'b0);
      ramp("f4r3", 1'b0, 1'b1);
      ramp("f2r0", 1'b1, 1'b0);
      ramp("f2r1", 1'b0, 1'b1);
      // RAW drain, then XFER with ft245_empty and ramp_start together
      nramps = 8'd1; mode = 1'b1; ramp_start = 1'b1;
      tick();
      ramp_start = 1'b0; fifo_full = 1'b1; mode = 1'b0;
      chk("raw_fir", ev(S_FIR, 1, 0, 0, 0, 0, 1, 0, 2'd0));
      tick();
      fifo_full = 1'b0;
      for (int i = 0; i < 8; i++) begin
         fifo_empty = 1'b0;
         chk("raw_drain", ev(S_PROC, 0, 0, 1, 0, 1, 0, 0, 2'd0));
         tick();
      end
      fifo_empty = 1'b1;
      chk("raw_empty", ev(S_PROC, 0, 0, 0, 0, 0, 0, 0, 2'd0));
      tick();
      ft245_empty = 1'b1; ramp_start = 1'b1; mode = 1'b0;
      chk("raw_xfer", ev(S_XFER, 0, 0, 0, 0, 0, 0, 0, 2'd0));
      tick();
      ft245_empty = 1'b0; ramp_start = 1'b0; fifo_full = 1'b1;
      chk("xfer_to_fir", ev(S_FIR, 1, 0, 0, 0, 0, 1, 1, 2'd0));
      tick();
      fifo_full = 1'b0; rst_n = 1'b0;
      chk("fft_relatched", ev(S_PROC, 0, 0, 1, 0, 0, 0, 0, 2'd0));
      // reset during PROC aborts without frame_done
      tick();
      rst_n = 1'b1;
      chk("abort_reset", ev(S_CFG, 0, 0, 0, 0, 0, 0, 0, 2'd0));
      tick();
      chk("rearm", ev(S_ARM, 0, 0, 0, 0, 0, 0, 0, 2'd0));
      // skipped ramps while FT245 is busy
      ramp_start = 1'b1;
      tick();
      ramp_start = 1'b0; fifo_full = 1'b1;
      tick();
      fifo_full = 1'b0;
      tick(); tick(); tick();
      fft_done = 1'b1;
      chk("skip_fft", ev(S_PROC, 0, 0, 1, 1, 0, 0, 0, 2'd0));
      tick();
      fft_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ramp_start = 1'b1;
`ifdef ACQ_SEQ_STATS_EN
         sk_exp = (i > 3) ? 2'd3 : 2'(i);
`else
         sk_exp = 2'd0;
`endif
         chk("skip_stay", ev(S_XFER, 0, 0, 0, 0, 0, 0, 0, sk_exp));
         tick();
      end
      ramp_start = 1'b0; ft245_empty = 1'b1;
`ifdef ACQ_SEQ_STATS_EN
      sk_exp = 2'd3;
`else
      sk_exp = 2'd0;
`endif
      chk("skip_sat", ev(S_XFER, 0, 0, 0, 0, 0, 0, 0, sk_exp));
      tick();
      ft245_empty = 1'b0;
      chk("skip_done", ev(S_ARM, 0, 0, 0, 0, 0, 0, 1, sk_exp));
      tick();
      tick();
      if (sb.size() != 0) begin
         n_cmp = n_cmp + 1;
         n_bad = n_bad + 1;
         $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
